// File: rtl/bird_motion.sv
// bird_motion -- vertical-motion controller for the Flappy Bird bird.
//
// Keeps track of the bird's row. On each game tick it applies flap impulses
// and gravity. It also decodes the row into a one-hot ROWS x COLS bitmap,
// which feeds both the display and the collision logic.
//
// Optional feature macro: BIRD_FLOOR_KILL_EN
//   defined   -> a fall onto the floor row enters DEAD; dead=1 until reset.
//   undefined -> no DEAD state, dead tied 0, bird rests on the floor.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   tick      game-step strobe, one clk wide
//   flap      player button (level); edge-detected internally
//   position  [ROWS-1:0][COLS-1:0] bitmap, only [bird_row][BIRD_COL] set
//   bird_row  current row (0 = top)
//   at_top    bird_row == 0
//   at_floor  bird_row == ROWS-1
//   dead      game over (macro build only, else 0)
module bird_motion #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int BIRD_COL  = 11,
  parameter int START_ROW = 7,
  parameter int FALL_DIV  = 2,
  parameter int FLAP_RISE = 3,
  localparam int RW       = $clog2(ROWS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           flap,
  output logic [ROWS-1:0][COLS-1:0]      position,
  output logic [RW-1:0]                  bird_row,
  output logic                           at_top,
  output logic                           at_floor,
  output logic                           dead
);

  localparam int RCW = $clog2(FLAP_RISE + 1);
  localparam int FCW = $clog2(FALL_DIV + 1);
  localparam logic [RCW-1:0]  RISE_LD  = RCW'(FLAP_RISE - 1);
  localparam logic [FCW-1:0]  FALL_TOP = FCW'(FALL_DIV - 1);
  localparam logic [RW-1:0]   ROW_MAX  = RW'(ROWS - 1);
  localparam logic [RW-1:0]   ROW_INIT = RW'(START_ROW);
  localparam logic [COLS-1:0] COL_MASK = COLS'(1) << BIRD_COL;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    FALL
`ifdef BIRD_FLOOR_KILL_EN
    , DEAD
`endif
  } state_t;

  state_t         state, state_n;
  logic [RW-1:0]  row_n, row_up, row_dn;
  logic [RCW-1:0] rise_cnt, rise_cnt_n;
  logic [FCW-1:0] fall_cnt, fall_cnt_n;
  logic           flap_q, flap_pend, flap_evt, flap_go;

  // A flap edge landing on the same cycle as a tick counts for that tick.
  assign flap_evt = flap & ~flap_q;
  assign flap_go  = flap_pend | flap_evt;

  // Saturating one-row moves; the row never wraps.
  assign row_up = (bird_row == '0)      ? '0      : bird_row - RW'(1);
  assign row_dn = (bird_row == ROW_MAX) ? ROW_MAX : bird_row + RW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bird_row  <= ROW_INIT;
      rise_cnt  <= '0;
      fall_cnt  <= '0;
      flap_q    <= 1'b0;
      flap_pend <= 1'b0;
    end else begin
      state     <= state_n;
      bird_row  <= row_n;
      rise_cnt  <= rise_cnt_n;
      fall_cnt  <= fall_cnt_n;
      flap_q    <= flap;
      // Pending flap survives until the next tick consumes it.
      if (tick)          flap_pend <= 1'b0;
      else if (flap_evt) flap_pend <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    row_n      = bird_row;
    rise_cnt_n = rise_cnt;
    fall_cnt_n = fall_cnt;
    if (tick) begin
      case (state)
        IDLE: begin
          if (flap_go) begin
            state_n    = RISE;
            row_n      = row_up;
            rise_cnt_n = RISE_LD;
          end
        end
        RISE: begin
          if (flap_go) begin
            row_n      = row_up;
            rise_cnt_n = RISE_LD;
          end else if (rise_cnt != '0) begin
            row_n      = row_up;
            rise_cnt_n = rise_cnt - RCW'(1);
          end else begin
            state_n    = FALL;
            fall_cnt_n = '0;
          end
        end
        FALL: begin
          if (flap_go) begin
            state_n    = RISE;
            row_n      = row_up;
            rise_cnt_n = RISE_LD;
            fall_cnt_n = '0;
          end else if (fall_cnt == FALL_TOP) begin
            row_n      = row_dn;
            fall_cnt_n = '0;
`ifdef BIRD_FLOOR_KILL_EN
            if (row_dn == ROW_MAX) state_n = DEAD;
`endif
          end else begin
            fall_cnt_n = fall_cnt + FCW'(1);
          end
        end
        default: ; // DEAD: frozen until reset
      endcase
    end
  end

`ifdef BIRD_FLOOR_KILL_EN
  assign dead = (state == DEAD);
`else
  assign dead = 1'b0;
`endif

  assign at_top   = (bird_row == '0);
  assign at_floor = (bird_row == ROW_MAX);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [RW-1:0] RI = RW'(r);
    assign position[r] = (bird_row == RI) ? COL_MASK : '0;
  end

endmodule

// File: tb/tb_bird_motion.sv
module tb_bird_motion;
  localparam int ROWS = 16, COLS = 16, BIRD_COL = 11;

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, flap = 1'b0;
  logic [ROWS-1:0][COLS-1:0] position;
  logic [3:0] bird_row;
  logic at_top, at_floor, dead;

  int checks = 0, errors = 0;
  int exp_q[$];
  logic exp_dead = 1'b0;

  bird_motion dut (
    .clk(clk), .reset(reset), .tick(tick), .flap(flap),
    .position(position), .bird_row(bird_row), .at_top(at_top),
    .at_floor(at_floor), .dead(dead)
  );

  always #5 clk = ~clk;

  // One clk cycle: drive inputs, queue the expected row, compare after the edge.
  task automatic step(input logic r, input logic t, input logic f, input int exp_row);
    int e;
    logic [ROWS-1:0][COLS-1:0] exp_pos;
    @(negedge clk);
    reset = r; tick = t; flap = f;
    exp_q.push_back(exp_row);
    @(posedge clk);
    #1;
    tick = 1'b0; reset = 1'b0;
    e = exp_q.pop_front();
    exp_pos = '0;
    exp_pos[e][BIRD_COL] = 1'b1;
    checks++;
    assert (bird_row === 4'(e)) else begin
      errors++; $error("FAIL row: got %0d want %0d", bird_row, e);
    end
    checks++;
    assert (position === exp_pos) else begin
      errors++; $error("FAIL position: got %h want %h", position, exp_pos);
    end
    checks++;
    assert (at_top === (e == 0) && at_floor === (e == ROWS-1)) else begin
      errors++; $error("FAIL flags: got top=%b floor=%b want row %0d", at_top, at_floor, e);
    end
    checks++;
    assert (dead === exp_dead) else begin
      errors++; $error("FAIL dead: got %b want %b", dead, exp_dead);
    end
  endtask

  initial begin
    // 1. reset, idle ticks
    step(1, 0, 0, 7);
    step(1, 0, 0, 7);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 7);

    // 2. single flap: 3-row rise, then fall every second tick
    step(0, 1, 1, 6);
    step(0, 1, 0, 5);
    step(0, 0, 0, 5);
    step(0, 1, 0, 4);
    step(0, 1, 0, 4);
    step(0, 1, 0, 4);
    step(0, 1, 0, 5);
    step(0, 1, 0, 5);
    step(0, 1, 0, 6);

    // 3. flap held high: one rise only
    step(1, 0, 0, 7);
    step(0, 1, 1, 6);
    step(0, 1, 1, 5);
    step(0, 1, 1, 4);
    step(0, 1, 1, 4);
    step(0, 1, 1, 4);
    step(0, 1, 1, 5);
    step(0, 1, 1, 5);
    step(0, 1, 1, 6);
    step(0, 1, 1, 6);
    step(0, 1, 1, 7);
    step(0, 0, 0, 7);

    // 4. flap every tick: climb to top, saturate at 0
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 1, (7 - i < 0) ? 0 : 7 - i);
      step(0, 0, 0, (7 - i < 0) ? 0 : 7 - i);
    end

    // 5. no flaps: rise drains at row 0, then one row per two ticks to floor
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
`ifdef BIRD_FLOOR_KILL_EN
      if (k == 30) exp_dead = 1'b1;
`endif
      step(0, 1, 0, k / 2);
    end
    step(0, 1, 0, 15);
    step(0, 1, 0, 15);
`ifdef BIRD_FLOOR_KILL_EN
    step(0, 1, 1, 15);
    step(0, 0, 0, 15);
    step(0, 1, 0, 15);
`else
    step(0, 1, 1, 14);
    step(0, 0, 0, 14);
`endif

    // 6. pending flap applies on a later tick; reset drops a pending flap
    exp_dead = 1'b0;
    step(1, 0, 0, 7);
    step(0, 1, 1, 6);
    step(0, 0, 0, 6);
    step(0, 0, 1, 6);
    step(0, 0, 0, 6);
    step(0, 1, 0, 5);
    step(0, 0, 1, 5);
    step(1, 1, 1, 7);
    step(0, 1, 0, 7);
    step(0, 1, 0, 7);
    step(0, 1, 0, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
